// File: rtl/dmem_responder_if.sv
// Request/response bundle between a load/store requester and dmem_responder.
//   req_valid/req_ready      request handshake
//   req_we                   1 = store, 0 = load
//   req_addr                 byte address
//   req_size                 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned             loads: 1 = zero-extend, 0 = sign-extend
//   req_wdata                store data, right-aligned
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata                extended load data (0 for stores and errors)
//   rsp_err                  access was illegal
// master = requester side, slave = responder side.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder with programmable access latency and one outstanding request.
// Decodes access size, steers byte lanes, sign/zero-extends loads and flags illegal
// accesses (size 11, misaligned half/word, word index beyond DEPTH_WORDS).
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (memory array itself is not reset)
//   bus    dmem_responder_if.slave request/response bundle
// Parameters:
//   DEPTH_WORDS  number of 32-bit words
//   LATENCY      cycles from request acceptance to rsp_valid, 1..15
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input logic            clk,
    input logic            rst_n,
    dmem_responder_if.slave bus
);

    localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic [3:0]  cnt_q, cnt_d;

    // Request captured at the acceptance edge; the live bus is never looked at again.
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] wdata_q, wdata_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [IdxW-1:0] idx;
    logic [31:0]     rd_word;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [31:0]     rd_ext;
    logic [3:0]      be;
    logic [31:0]     wlanes;
    logic            acc_err;
    logic            commit;
    logic            mem_we;
    logic            accept;

    assign idx     = addr_q[IdxW+1:2];
    assign rd_word = mem_q[idx];

    assign acc_err = (size_q == 2'b11)
                   | ((size_q == 2'b01) & addr_q[0])
                   | ((size_q == 2'b10) & (|addr_q[1:0]))
                   | ({2'b00, addr_q[31:2]} >= DEPTH_WORDS);

    // The access happens on the edge that leaves WAIT.
    assign commit = (state_q == StWait) && (cnt_q == 4'd0);
    assign mem_we = commit && we_q && !acc_err;
    assign accept = bus.req_valid && req_ready_q;

    always_comb begin
        unique case (addr_q[1:0])
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
    end

    assign rd_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

    // Lane steering: write data is replicated across lanes and the byte enables pick the
    // target lane(s); load data is pulled from the same lane(s) and extended.
    always_comb begin
        be     = 4'b0000;
        wlanes = 32'd0;
        rd_ext = 32'd0;
        case (size_q)
            2'b00: begin
                be     = 4'b0001 << addr_q[1:0];
                wlanes = {4{wdata_q[7:0]}};
                rd_ext = uns_q ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            end
            2'b01: begin
                be     = addr_q[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{wdata_q[15:0]}};
                rd_ext = uns_q ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
            end
            2'b10: begin
                be     = 4'b1111;
                wlanes = wdata_q;
                rd_ext = rd_word;
            end
            default: begin
                be     = 4'b0000;
                wlanes = 32'd0;
                rd_ext = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[idx][8*i +: 8] <= wlanes[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        size_d      = size_q;
        uns_d       = uns_q;
        wdata_d     = wdata_q;
        case (state_q)
            StIdle: begin
                // Also brings req_ready up on the first edge after reset.
                req_ready_d = 1'b1;
                if (accept) begin
                    we_d        = bus.req_we;
                    addr_d      = bus.req_addr;
                    size_d      = bus.req_size;
                    uns_d       = bus.req_unsigned;
                    wdata_d     = bus.req_wdata;
                    cnt_d       = 4'(LATENCY - 1);
                    req_ready_d = 1'b0;
                    state_d     = StWait;
                end
            end
            StWait: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = acc_err;
                    rsp_rdata_d = (we_q || acc_err) ? 32'd0 : rd_ext;
                    state_d     = StResp;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'd0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            wdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            wdata_q     <= wdata_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule
